regfile_fwd: RTL and testbench
==============================

Name: regfile_fwd

Overview:
- 32x32 general-purpose register file for the five-stage pipeline, with forwarding from the EX and MEM stages.
- Consumes the result stream the execute path produces: write address, write enable and write data arrive from EX, from MEM, and finally from WB.
- Supplies two operands to ID in the same cycle they are requested.
- Raises a stall request when an operand depends on a load still in EX.

Parameters:
- DATA_W, 32, register/data width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  WB write enable.
- waddr  input  ADDR_W  WB write address.
- wdata  input  DATA_W  WB write data.
- ex_we  input  1  EX-stage result write enable.
- ex_waddr  input  ADDR_W  EX-stage destination.
- ex_wdata  input  DATA_W  EX-stage result.
- ex_is_load  input  1  EX instruction is a load; its data is not yet valid.
- mem_we  input  1  MEM-stage write enable.
- mem_waddr  input  ADDR_W  MEM-stage destination.
- mem_wdata  input  DATA_W  MEM-stage result.
- re1  input  1  read enable, port 1.
- raddr1  input  ADDR_W  read address, port 1.
- re2  input  1  read enable, port 2.
- raddr2  input  ADDR_W  read address, port 2.
- rdata1  output  DATA_W  operand 1 (combinational).
- rdata2  output  DATA_W  operand 2 (combinational).
- stallreq  output  1  load-use hazard; ID must hold.

Behaviour:
- Reset:
  - rst high clears all 32 registers to 0 immediately, without waiting for clk.
  - While rst is high: rdata1 = rdata2 = 0, stallreq = 0, writes ignored.
  - Deassertion takes effect on the next rising edge.
- Write:
  - On a rising edge with we=1 and waddr!=0, the register at waddr takes wdata.
  - Writes to address 0 are discarded; register 0 reads 0 always.
- Read (per port n, purely combinational, zero latency):
  - re_n=0 -> 0.
  - raddr_n=0 -> 0, regardless of any forwarding source targeting 0.
  - Otherwise the first match in this priority order drives the port:
    1. EX: ex_we=1 and ex_waddr=raddr_n, giving ex_wdata. This applies even when ex_is_load=1; stallreq covers that case.
    2. MEM: mem_we=1 and mem_waddr=raddr_n, giving mem_wdata.
    3. WB: we=1 and waddr=raddr_n, giving wdata (write-through, same cycle as the write).
    4. Otherwise the stored register value.
- Simultaneous events:
  - EX, MEM and WB all targeting the same address: the EX value wins (youngest result).
  - Both ports reading the same address return identical data.
- stallreq:
  - Asserted when ex_is_load=1, ex_we=1, ex_waddr!=0, and for some port re_n=1 and raddr_n=ex_waddr.
  - Combinational; no registered state.
  - Held for as long as the condition holds; the pipeline resolves it by advancing the load to MEM.
- Width: all data DATA_W, no extension or truncation; addresses compared at full ADDR_W.
- X-safety: an unenabled forwarding source never affects output, whatever its address or data.

Test Plan:
- Reset:
  - Write 0x1234 to r5.
  - Assert rst mid-cycle (not on an edge).
  - Required: rdata1 with raddr1=5 reads 0 immediately.
  - Deassert rst, read r5 -> 0.
- Write/read and r0:
  - Write 0xDEADBEEF to r7 via WB; read next cycle -> 0xDEADBEEF.
  - Write 0xFFFFFFFF to r0 -> reads 0.
  - Set ex_we=1, ex_waddr=0, ex_wdata=5, read r0 -> 0.
- WB write-through:
  - Same cycle: we=1, waddr=3, wdata=0xA5A5A5A5, raddr2=3.
  - Required: rdata2=0xA5A5A5A5 in that cycle; the array holds the value after the edge.
- Priority:
  - r9 stored as 1, WB=2, MEM=3, EX=4, all targeting r9 -> rdata1=4.
  - Drop ex_we -> 3.
  - Drop mem_we -> 2.
  - Drop we -> 1.
  - re1=0 -> 0.
- Load-use stall:
  - ex_is_load=1, ex_we=1, ex_waddr=8, re2=1, raddr2=8 -> stallreq=1.
  - Change raddr2 to 9 -> 0.
  - re2=0 -> 0.
  - ex_waddr=0 with reads of r0 -> 0.
- Random regression:
  - 10k cycles of random writes, forwards and reads against a reference model.
  - No mismatches permitted; r0 reads 0 throughout.

Source files
------------

// File: rtl/regfile_fwd_if.sv
// Register-file bus: WB write port, EX/MEM forwarding sources, two read ports
// and the load-use stall request. The pipeline drives it as master; the
// register file is the slave.
interface regfile_fwd_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              ex_we;
    logic [ADDR_W-1:0] ex_waddr;
    logic [DATA_W-1:0] ex_wdata;
    logic              ex_is_load;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              stallreq;

    modport master (
        output we, waddr, wdata,
        output ex_we, ex_waddr, ex_wdata, ex_is_load,
        output mem_we, mem_waddr, mem_wdata,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, stallreq
    );

    modport slave (
        input  we, waddr, wdata,
        input  ex_we, ex_waddr, ex_wdata, ex_is_load,
        input  mem_we, mem_waddr, mem_wdata,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rdata2, stallreq
    );
endinterface

// File: rtl/regfile_fwd.sv
// 32x32 register file with EX > MEM > WB forwarding on both read ports and a
// load-use stall request. Register 0 is hardwired to zero.
module regfile_fwd #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    regfile_fwd_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Youngest matching in-flight result wins; r0 and disabled ports read zero.
    function automatic logic [DATA_W-1:0] operand(input logic              re,
                                                  input logic [ADDR_W-1:0] raddr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (!re || raddr == '0)
            val = '0;
        else if (bus.ex_we && bus.ex_waddr == raddr)
            val = bus.ex_wdata;
        else if (bus.mem_we && bus.mem_waddr == raddr)
            val = bus.mem_wdata;
        else if (bus.we && bus.waddr == raddr)
            val = bus.wdata;
        else
            val = regs[raddr];
        return val;
    endfunction

    // Storage: async clear, WB write on the rising edge, r0 never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (bus.we && bus.waddr != '0) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // Operand mux and stall detect; everything is forced quiet while in reset
    // so forwarding sources cannot leak through before the pipeline restarts.
    always_comb begin
        bus.rdata1   = '0;
        bus.rdata2   = '0;
        bus.stallreq = 1'b0;
        if (!rst) begin
            bus.rdata1   = operand(bus.re1, bus.raddr1);
            bus.rdata2   = operand(bus.re2, bus.raddr2);
            bus.stallreq = bus.ex_is_load && bus.ex_we && (bus.ex_waddr != '0) &&
                           ((bus.re1 && bus.raddr1 == bus.ex_waddr) ||
                            (bus.re2 && bus.raddr2 == bus.ex_waddr));
        end
    end
endmodule

// File: tb/tb_regfile_fwd.sv
// Directed and random checks of regfile_fwd against hand-computed values and
// a small reference model of the register array.
module tb_regfile_fwd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] model [32];

    regfile_fwd_if bus ();

    regfile_fwd dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.we = 0;        bus.waddr = 0;     bus.wdata = 0;
        bus.ex_we = 0;     bus.ex_waddr = 0;  bus.ex_wdata = 0;  bus.ex_is_load = 0;
        bus.mem_we = 0;    bus.mem_waddr = 0; bus.mem_wdata = 0;
        bus.re1 = 0;       bus.raddr1 = 0;
        bus.re2 = 0;       bus.raddr2 = 0;
    endtask

    // Drive a WB write that commits on the next rising edge.
    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        idle();
        bus.we = 1; bus.waddr = a; bus.wdata = d;
        @(posedge clk); #1;
        idle();
    endtask

    function automatic logic [31:0] ref_read(input logic re, input logic [4:0] a);
        if (!re || a == 0) return 32'h0;
        if (bus.ex_we && bus.ex_waddr == a) return bus.ex_wdata;
        if (bus.mem_we && bus.mem_waddr == a) return bus.mem_wdata;
        if (bus.we && bus.waddr == a) return bus.wdata;
        return model[a];
    endfunction

    initial begin
        idle();
        for (int i = 0; i < 32; i++) model[i] = 0;
        #12;
        // Reset held from time 0: outputs quiet even with a load hazard set up.
        bus.re1 = 1; bus.raddr1 = 4; bus.ex_we = 1; bus.ex_waddr = 4;
        bus.ex_wdata = 32'h77; bus.ex_is_load = 1;
        #1;
        check("rst_rdata1", bus.rdata1, 32'h0);
        check("rst_stall", {31'b0, bus.stallreq}, 32'h0);
        idle();
        rst = 0;

        // Reset clears stored data asynchronously.
        wb_write(5, 32'h1234);
        bus.re1 = 1; bus.raddr1 = 5;
        #1;
        check("pre_rst_r5", bus.rdata1, 32'h1234);
        #2 rst = 1;
        #1;
        check("async_rst_r5", bus.rdata1, 32'h0);
        @(posedge clk); #3 rst = 0;
        @(posedge clk); #1;
        bus.re1 = 1; bus.raddr1 = 5;
        #1;
        check("post_rst_r5", bus.rdata1, 32'h0);

        // Plain write/read and r0.
        wb_write(7, 32'hDEADBEEF);
        bus.re1 = 1; bus.raddr1 = 7;
        #1;
        check("r7_read", bus.rdata1, 32'hDEADBEEF);
        wb_write(0, 32'hFFFFFFFF);
        bus.re1 = 1; bus.raddr1 = 0;
        #1;
        check("r0_after_write", bus.rdata1, 32'h0);
        bus.ex_we = 1; bus.ex_waddr = 0; bus.ex_wdata = 5;
        #1;
        check("r0_ex_fwd", bus.rdata1, 32'h0);

        // WB write-through, then the array holds the value.
        @(posedge clk); #1;
        idle();
        bus.we = 1; bus.waddr = 3; bus.wdata = 32'hA5A5A5A5;
        bus.re2 = 1; bus.raddr2 = 3;
        #1;
        check("wb_through", bus.rdata2, 32'hA5A5A5A5);
        @(posedge clk); #1;
        bus.we = 0;
        #1;
        check("r3_stored", bus.rdata2, 32'hA5A5A5A5);
        bus.re1 = 1; bus.raddr1 = 3;
        #1;
        check("same_addr_p1", bus.rdata1, 32'hA5A5A5A5);
        idle();

        // Forwarding priority EX > MEM > WB > array.
        wb_write(9, 32'h1);
        bus.re1 = 1; bus.raddr1 = 9;
        bus.we = 1;     bus.waddr = 9;     bus.wdata = 32'h2;
        bus.mem_we = 1; bus.mem_waddr = 9; bus.mem_wdata = 32'h3;
        bus.ex_we = 1;  bus.ex_waddr = 9;  bus.ex_wdata = 32'h4;
        #1; check("prio_ex", bus.rdata1, 32'h4);
        bus.ex_we = 0;
        #1; check("prio_mem", bus.rdata1, 32'h3);
        bus.mem_we = 0;
        #1; check("prio_wb", bus.rdata1, 32'h2);
        bus.we = 0;
        #1; check("prio_reg", bus.rdata1, 32'h1);
        bus.re1 = 0;
        #1; check("re1_off", bus.rdata1, 32'h0);

        // Load-use stall.
        @(posedge clk); #1;
        idle();
        bus.ex_is_load = 1; bus.ex_we = 1; bus.ex_waddr = 8; bus.ex_wdata = 32'h88;
        bus.re2 = 1; bus.raddr2 = 8;
        #1; check("stall_hit", {31'b0, bus.stallreq}, 32'h1);
        check("load_fwd_data", bus.rdata2, 32'h88);
        bus.raddr2 = 9;
        #1; check("stall_miss", {31'b0, bus.stallreq}, 32'h0);
        bus.raddr2 = 8; bus.re2 = 0;
        #1; check("stall_re_off", {31'b0, bus.stallreq}, 32'h0);
        bus.re1 = 1; bus.raddr1 = 8;
        #1; check("stall_port1", {31'b0, bus.stallreq}, 32'h1);
        bus.ex_waddr = 0; bus.raddr1 = 0; bus.re2 = 1; bus.raddr2 = 0;
        #1; check("stall_r0", {31'b0, bus.stallreq}, 32'h0);
        idle();

        // Random regression against the reference model.
        for (int i = 0; i < 32; i++) model[i] = 0;
        model[5] = 0; model[7] = 32'hDEADBEEF; model[3] = 32'hA5A5A5A5; model[9] = 32'h1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk); #1;
            bus.we = 1'($urandom_range(0, 1));
            bus.waddr = 5'($urandom_range(0, 9));
            bus.wdata = $urandom;
            bus.ex_we = 1'($urandom_range(0, 2) == 0);
            bus.ex_waddr = 5'($urandom_range(0, 9));
            bus.ex_wdata = $urandom;
            bus.ex_is_load = 1'($urandom_range(0, 1));
            bus.mem_we = 1'($urandom_range(0, 2) == 0);
            bus.mem_waddr = 5'($urandom_range(0, 9));
            bus.mem_wdata = $urandom;
            bus.re1 = 1'($urandom_range(0, 3) != 0);
            bus.raddr1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
            bus.re2 = 1'($urandom_range(0, 3) != 0);
            bus.raddr2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
            #1;
            check("rnd_rdata1", bus.rdata1, ref_read(bus.re1, bus.raddr1));
            check("rnd_rdata2", bus.rdata2, ref_read(bus.re2, bus.raddr2));
            check("rnd_stall", {31'b0, bus.stallreq},
                  {31'b0, bus.ex_is_load && bus.ex_we && bus.ex_waddr != 0 &&
                          ((bus.re1 && bus.raddr1 == bus.ex_waddr) ||
                           (bus.re2 && bus.raddr2 == bus.ex_waddr))});
            if (bus.we && bus.waddr != 0) model[bus.waddr] = bus.wdata;
        end
        @(posedge clk); #1;
        idle();

        // Final sweep of the stored array.
        for (int a = 0; a < 32; a++) begin
            bus.re1 = 1; bus.raddr1 = 5'(a);
            #1;
            check("final_sweep", bus.rdata1, model[a]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
